// File: rtl/rank_order_encoder.sv
// Rank-order encoder: converts a snapshotted image into an event stream. The
// stream is PRE_EVENTS sync codes followed by pixel indices in descending
// intensity order, with ties broken by ascending index. Only pixels at or above
// a programmable threshold are emitted. Events leave through a valid/ready
// handshake, and the block counts the pixel events it has emitted.
`timescale 1ns/1ps
module rank_order_encoder #(
  parameter int IMAGE_SIZE = 256,
  parameter int PIXEL_BITS = 8,
  parameter int LANES      = 4,
  parameter int PRE_EVENTS = 2,
  parameter int IDX_BITS   = $clog2(IMAGE_SIZE) + 2,
  parameter logic [IDX_BITS-1:0] SYNC_CODE =
    IDX_BITS'({2'b01, {$clog2(IMAGE_SIZE){1'b1}}})
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [PIXEL_BITS-1:0]      IMAGE [IMAGE_SIZE],
  input  logic                       NEW_IMAGE,
  input  logic [PIXEL_BITS-1:0]      THRESHOLD,
  input  logic                       ABORT,
  output logic                       EV_VALID,
  input  logic                       EV_READY,
  output logic [IDX_BITS-1:0]        EV_DATA,
  output logic                       BUSY,
  output logic                       IMAGE_ENCODED,
  output logic [$clog2(IMAGE_SIZE):0] EVENT_COUNT
);

  localparam int IW      = $clog2(IMAGE_SIZE);
  localparam int CW      = IW + 1;
  localparam int NGROUPS = IMAGE_SIZE / LANES;
  localparam int GW      = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
  localparam int LB      = $clog2(LANES);
  localparam int SW      = (PRE_EVENTS > 1) ? $clog2(PRE_EVENTS) : 1;

  typedef enum logic [2:0] {IDLE, SYNC, SCAN, EMIT, DONE} state_t;

  state_t                state, state_next;

  logic [PIXEL_BITS-1:0] pix [IMAGE_SIZE];
  logic [PIXEL_BITS-1:0] thr;
  logic [IMAGE_SIZE-1:0] mask;
  logic [PIXEL_BITS-1:0] intensity;
  logic [GW-1:0]         group;
  logic [SW-1:0]         sync_cnt;
  logic                  ev_valid;
  logic [IDX_BITS-1:0]   ev_data;
  logic [CW-1:0]         event_count;

  logic [IW-1:0]         base;
  logic [IW-1:0]         lane_idx;
  logic [IW-1:0]         hit_idx;
  logic                  hit;
  logic                  group_last;
  logic                  sync_last;
  logic [CW-1:0]         cnt_inc;
  logic                  count_last;
  logic                  abort_now;

  assign group_last = (group == GW'(NGROUPS - 1));
  assign sync_last  = (sync_cnt == SW'(PRE_EVENTS - 1));
  assign cnt_inc    = event_count + CW'(1);
  assign count_last = (cnt_inc == CW'(IMAGE_SIZE));
  assign abort_now  = ABORT && (state != IDLE);

  // Pick the lowest unemitted lane of the current group matching the intensity.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    lane_idx = '0;
    base     = IW'(group) << LB;
    for (int k = LANES - 1; k >= 0; k--) begin
      lane_idx = base + IW'(k);
      if ((pix[lane_idx] == intensity) && !mask[lane_idx]) begin
        hit     = 1'b1;
        hit_idx = lane_idx;
      end
    end
  end

  // Next-state decode and status outputs; abort overrides everything.
  always_comb begin
    state_next    = state;
    BUSY          = (state != IDLE);
    IMAGE_ENCODED = (state == DONE);
    case (state)
      IDLE: if (NEW_IMAGE) state_next = (PRE_EVENTS > 0) ? SYNC : SCAN;
      SYNC: if (EV_READY && sync_last) state_next = SCAN;
      SCAN: begin
        if (hit)                                   state_next = EMIT;
        else if (group_last && (intensity == thr)) state_next = DONE;
      end
      EMIT: if (EV_READY) state_next = count_last ? DONE : SCAN;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort_now) state_next = IDLE;
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // Image and threshold snapshot taken at start; later input changes are ignored.
  always_ff @(posedge CLK) begin
    if ((state == IDLE) && NEW_IMAGE) begin
      pix <= IMAGE;
      thr <= THRESHOLD;
    end
  end

  // Scan position, emitted mask, output event register and event counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ev_valid    <= 1'b0;
      ev_data     <= '0;
      event_count <= '0;
      mask        <= '0;
      intensity   <= '1;
      group       <= '0;
      sync_cnt    <= '0;
    end else if (abort_now) begin
      ev_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (NEW_IMAGE) begin
            mask        <= '0;
            event_count <= '0;
            intensity   <= '1;
            group       <= '0;
            sync_cnt    <= '0;
            if (PRE_EVENTS > 0) begin
              ev_valid <= 1'b1;
              ev_data  <= SYNC_CODE;
            end
          end
        end
        SYNC: begin
          if (EV_READY) begin
            sync_cnt <= sync_cnt + SW'(1);
            if (sync_last) ev_valid <= 1'b0;
          end
        end
        SCAN: begin
          if (hit) begin
            ev_data       <= IDX_BITS'(hit_idx);
            mask[hit_idx] <= 1'b1;
            ev_valid      <= 1'b1;
          end else if (!group_last) begin
            group <= group + GW'(1);
          end else if (intensity != thr) begin
            intensity <= intensity - PIXEL_BITS'(1);
            group     <= '0;
          end
        end
        EMIT: begin
          if (EV_READY) begin
            ev_valid    <= 1'b0;
            event_count <= cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign EV_VALID    = ev_valid;
  assign EV_DATA     = ev_data;
  assign EVENT_COUNT = event_count;

endmodule

// File: tb/tb_rank_order_encoder.sv
// Directed testbench for rank_order_encoder: a small 8-pixel instance covers
// ordering, threshold, back-pressure, abort, restart protection and reset; a
// default-parameter instance covers the all-maximum early-exit case.
`timescale 1ns/1ps
module tb_rank_order_encoder;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] image [N];
  logic       new_image;
  logic [7:0] threshold;
  logic       abort;
  logic       ev_valid;
  logic       ev_ready;
  logic [4:0] ev_data;
  logic       busy;
  logic       image_encoded;
  logic [3:0] event_count;

  logic [7:0] image2 [256];
  logic       new_image2;
  logic [7:0] threshold2;
  logic       abort2;
  logic       ev_valid2;
  logic       ev_ready2;
  logic [9:0] ev_data2;
  logic       busy2;
  logic       encoded2;
  logic [8:0] count2;

  int total = 0;
  int bad   = 0;

  int ev_q[$];
  bit enc_seen, aborted, timed_out;
  int stall_bad, first_valid_n, last_hs_n, enc_n;

  logic [7:0] img_a [N];
  logic [7:0] img_b [N];
  int exp_full [10] = '{15, 15, 1, 2, 5, 4, 0, 7, 6, 3};
  int exp_thr  [7]  = '{15, 15, 1, 2, 5, 4, 0};

  always #5 clk = ~clk;

  rank_order_encoder #(.IMAGE_SIZE(N), .PIXEL_BITS(8), .LANES(4), .PRE_EVENTS(2)) dut (
    .CLK(clk), .RST(rst), .IMAGE(image), .NEW_IMAGE(new_image), .THRESHOLD(threshold),
    .ABORT(abort), .EV_VALID(ev_valid), .EV_READY(ev_ready), .EV_DATA(ev_data),
    .BUSY(busy), .IMAGE_ENCODED(image_encoded), .EVENT_COUNT(event_count)
  );

  rank_order_encoder dut2 (
    .CLK(clk), .RST(rst), .IMAGE(image2), .NEW_IMAGE(new_image2), .THRESHOLD(threshold2),
    .ABORT(abort2), .EV_VALID(ev_valid2), .EV_READY(ev_ready2), .EV_DATA(ev_data2),
    .BUSY(busy2), .IMAGE_ENCODED(encoded2), .EVENT_COUNT(count2)
  );

  task automatic start_image(input logic [7:0] thr);
    @(negedge clk);
    threshold = thr;
    new_image = 1'b1;
  endtask

  // Collects accepted events until IMAGE_ENCODED, abort or budget expiry.
  // stall_on: event value to hold off for 5 cycles; abort_on: event value to
  // abort on together with ready; poke_at: cycle to re-pulse NEW_IMAGE with img_b.
  task automatic run_events(input int budget, input int stall_on,
                            input int abort_on, input int poke_at);
    int  n = 0;
    int  stall_left = 0;
    bit  stalled = 1'b0;
    ev_q.delete();
    enc_seen = 1'b0; aborted = 1'b0; stall_bad = 0;
    first_valid_n = -1; last_hs_n = -1; enc_n = -1;
    while (!enc_seen && !aborted && n < budget) begin
      @(negedge clk);
      n++;
      new_image = 1'b0;
      if (n == poke_at) begin
        new_image = 1'b1;
        image = img_b;
        threshold = 8'd200;
      end
      if (ev_valid && first_valid_n < 0) first_valid_n = n;
      if (stall_left > 0) begin
        if (!ev_valid || int'(ev_data) != stall_on) stall_bad++;
        stall_left--;
        if (stall_left == 0) ev_ready = 1'b1;
      end else if (!stalled && ev_valid && int'(ev_data) == stall_on) begin
        stalled = 1'b1;
        ev_ready = 1'b0;
        stall_left = 5;
      end
      if (ev_valid && ev_ready) begin
        if (int'(ev_data) == abort_on) begin
          abort = 1'b1;
          aborted = 1'b1;
        end else begin
          ev_q.push_back(int'(ev_data));
          last_hs_n = n;
        end
      end
      if (image_encoded) begin
        enc_seen = 1'b1;
        enc_n = n;
      end
    end
    new_image = 1'b0;
    timed_out = !enc_seen && !aborted;
  endtask

  task automatic test_reset();
    rst = 1'b1; new_image = 1'b0; abort = 1'b0; ev_ready = 1'b1; threshold = 8'd0;
    new_image2 = 1'b0; abort2 = 1'b0; ev_ready2 = 1'b1; threshold2 = 8'd0;
    image = img_a;
    for (int i = 0; i < 256; i++) image2[i] = 8'd255;
    repeat (3) @(negedge clk);
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL reset_ev_valid got=%b want=0", ev_valid); end
    total++; if (ev_data !== 5'd0) begin bad++; $display("FAIL reset_ev_data got=%0h want=0", ev_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (image_encoded !== 1'b0) begin bad++; $display("FAIL reset_encoded got=%b want=0", image_encoded); end
    total++; if (event_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", event_count); end
    total++; if ({ev_valid2, busy2, encoded2} !== 3'b000 || count2 !== 9'd0 || ev_data2 !== 10'd0) begin
      bad++; $display("FAIL reset_dut2 got=%b%b%b/%0d/%0h want=000/0/0", ev_valid2, busy2, encoded2, count2, ev_data2);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_order();
    image = img_a;
    start_image(8'd0);
    run_events(3000, -1, -1, -1);
    total++; if (timed_out) begin bad++; $display("FAIL order_timeout got=timeout want=encoded"); end
    total++; if (first_valid_n !== 1) begin bad++; $display("FAIL order_first_valid got=%0d want=1", first_valid_n); end
    total++; if (ev_q.size() !== 10) begin bad++; $display("FAIL order_len got=%0d want=10", ev_q.size()); end
    for (int i = 0; i < 10; i++) begin
      total++;
      if (i >= ev_q.size() || ev_q[i] !== exp_full[i]) begin
        bad++; $display("FAIL order_ev%0d got=%0d want=%0d", i, (i < ev_q.size()) ? ev_q[i] : -1, exp_full[i]);
      end
    end
    total++; if (event_count !== 4'd8) begin bad++; $display("FAIL order_count got=%0d want=8", event_count); end
    total++; if (enc_n - last_hs_n !== 1) begin bad++; $display("FAIL order_early_exit got=%0d want=1", enc_n - last_hs_n); end
    @(negedge clk);
    total++; if (image_encoded !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL order_pulse_len got=%b%b want=00", image_encoded, busy);
    end
  endtask

  task automatic test_threshold();
    image = img_a;
    start_image(8'd3);
    run_events(3000, -1, -1, -1);
    total++; if (!enc_seen) begin bad++; $display("FAIL thr_encoded got=0 want=1"); end
    total++; if (ev_q.size() !== 7) begin bad++; $display("FAIL thr_len got=%0d want=7", ev_q.size()); end
    for (int i = 0; i < 7; i++) begin
      total++;
      if (i >= ev_q.size() || ev_q[i] !== exp_thr[i]) begin
        bad++; $display("FAIL thr_ev%0d got=%0d want=%0d", i, (i < ev_q.size()) ? ev_q[i] : -1, exp_thr[i]);
      end
    end
    total++; if (event_count !== 4'd5) begin bad++; $display("FAIL thr_count got=%0d want=5", event_count); end
  endtask

  task automatic test_stall();
    image = img_a;
    start_image(8'd0);
    run_events(3000, 2, -1, -1);
    total++; if (stall_bad !== 0) begin bad++; $display("FAIL stall_hold got=%0d want=0", stall_bad); end
    total++; if (ev_q.size() !== 10) begin bad++; $display("FAIL stall_len got=%0d want=10", ev_q.size()); end
    for (int i = 0; i < 10; i++) begin
      total++;
      if (i >= ev_q.size() || ev_q[i] !== exp_full[i]) begin
        bad++; $display("FAIL stall_ev%0d got=%0d want=%0d", i, (i < ev_q.size()) ? ev_q[i] : -1, exp_full[i]);
      end
    end
    total++; if (event_count !== 4'd8) begin bad++; $display("FAIL stall_count got=%0d want=8", event_count); end
  endtask

  task automatic test_abort();
    bit enc_flag = 1'b0;
    image = img_a;
    start_image(8'd0);
    run_events(3000, -1, 5, -1);
    total++; if (!aborted) begin bad++; $display("FAIL abort_reached got=0 want=1"); end
    @(negedge clk);
    abort = 1'b0;
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL abort_valid got=%b want=0", ev_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
    total++; if (event_count !== 4'd2) begin bad++; $display("FAIL abort_count got=%0d want=2", event_count); end
    if (image_encoded) enc_flag = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (image_encoded) enc_flag = 1'b1;
    end
    total++; if (enc_flag !== 1'b0) begin bad++; $display("FAIL abort_no_encoded got=1 want=0"); end
    total++; if (event_count !== 4'd2) begin bad++; $display("FAIL abort_count_hold got=%0d want=2", event_count); end
    start_image(8'd0);
    run_events(3000, -1, -1, -1);
    total++; if (ev_q.size() !== 10) begin bad++; $display("FAIL restart_len got=%0d want=10", ev_q.size()); end
    for (int i = 0; i < 10; i++) begin
      total++;
      if (i >= ev_q.size() || ev_q[i] !== exp_full[i]) begin
        bad++; $display("FAIL restart_ev%0d got=%0d want=%0d", i, (i < ev_q.size()) ? ev_q[i] : -1, exp_full[i]);
      end
    end
    total++; if (event_count !== 4'd8) begin bad++; $display("FAIL restart_count got=%0d want=8", event_count); end
  endtask

  task automatic test_busy_ignore();
    image = img_a;
    start_image(8'd0);
    run_events(3000, -1, -1, 4);
    total++; if (ev_q.size() !== 10) begin bad++; $display("FAIL ignore_len got=%0d want=10", ev_q.size()); end
    for (int i = 0; i < 10; i++) begin
      total++;
      if (i >= ev_q.size() || ev_q[i] !== exp_full[i]) begin
        bad++; $display("FAIL ignore_ev%0d got=%0d want=%0d", i, (i < ev_q.size()) ? ev_q[i] : -1, exp_full[i]);
      end
    end
    image = img_a;
    threshold = 8'd0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    image = img_a;
    ev_ready = 1'b0;
    start_image(8'd0);
    @(negedge clk);
    new_image = 1'b0;
    total++; if (ev_valid !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL rstmid_pre got=%b%b want=11", ev_valid, busy);
    end
    #2 rst = 1'b1;
    #1;
    total++; if (ev_valid !== 1'b0 || busy !== 1'b0 || ev_data !== 5'd0 || event_count !== 4'd0) begin
      bad++; $display("FAIL rstmid_async got=%b%b/%0h/%0d want=00/0/0", ev_valid, busy, ev_data, event_count);
    end
    @(negedge clk);
    rst = 1'b0;
    ev_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_default_all_max();
    int q2[$];
    int n = 0;
    int lhs = -1;
    int en = -1;
    int cnt_at_enc = -1;
    bit ok_seq = 1'b1;
    @(negedge clk);
    new_image2 = 1'b1;
    while (en < 0 && n < 3000) begin
      @(negedge clk);
      n++;
      new_image2 = 1'b0;
      if (ev_valid2 && ev_ready2) begin
        q2.push_back(int'(ev_data2));
        lhs = n;
      end
      if (encoded2) begin
        en = n;
        cnt_at_enc = int'(count2);
      end
    end
    total++; if (en < 0) begin bad++; $display("FAIL max_timeout got=timeout want=encoded"); end
    total++; if (q2.size() !== 258) begin bad++; $display("FAIL max_len got=%0d want=258", q2.size()); end
    total++; if (q2.size() < 2 || q2[0] !== 32'h1FF || q2[1] !== 32'h1FF) begin
      bad++; $display("FAIL max_sync got=%0h,%0h want=1ff,1ff",
                      (q2.size() > 0) ? q2[0] : -1, (q2.size() > 1) ? q2[1] : -1);
    end
    for (int i = 0; i < 256; i++)
      if (i + 2 >= q2.size() || q2[i + 2] !== i) ok_seq = 1'b0;
    total++; if (!ok_seq) begin bad++; $display("FAIL max_order got=out_of_order want=0..255"); end
    total++; if (cnt_at_enc !== 256) begin bad++; $display("FAIL max_count got=%0d want=256", cnt_at_enc); end
    total++; if (en - lhs !== 1) begin bad++; $display("FAIL max_early_exit got=%0d want=1", en - lhs); end
  endtask

  initial begin
    img_a = '{8'd3, 8'd7, 8'd7, 8'd0, 8'd5, 8'd7, 8'd1, 8'd2};
    img_b = '{8'd250, 8'd0, 8'd0, 8'd250, 8'd0, 8'd0, 8'd0, 8'd0};
    test_reset();
    test_full_order();
    test_threshold();
    test_stall();
    test_abort();
    test_busy_ignore();
    test_reset_mid();
    test_default_all_max();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rank_order_encoder.md
Name: rank_order_encoder

Overview:
- Parametrised successor to the single-lane intensity sorter. Converts a snapshotted image into a rank-order event stream for the AER input controller.
- Stream order: PRE_EVENTS sync/reset codes first, then pixel indices. Indices go by descending intensity, ties by ascending index.
- New relative to the previous generation:
  - scans LANES pixels per cycle;
  - applies a programmable intensity threshold;
  - uses a valid/ready output handshake;
  - counts emitted events.
- Sits between the image loader and the AER input controller.

Parameters:
- IMAGE_SIZE, 256, pixels per image; must be a multiple of LANES.
- PIXEL_BITS, 8, bits per pixel.
- LANES, 4, pixels compared per scan cycle; power of 2, 1..IMAGE_SIZE.
- PRE_EVENTS, 2, sync events emitted before pixel events; 0 allowed.
- IDX_BITS, $clog2(IMAGE_SIZE)+2, event code width.
- SYNC_CODE, {2'b01,{$clog2(IMAGE_SIZE){1'b1}}}, sync event code; 0x1FF at default.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset.
- IMAGE  in  PIXEL_BITS x IMAGE_SIZE  unpacked pixel array, index 0 first.
- NEW_IMAGE  in  1  start request; sampled only in IDLE.
- THRESHOLD  in  PIXEL_BITS  lowest intensity emitted; sampled with NEW_IMAGE.
- ABORT  in  1  inference done; terminates the current image.
- EV_VALID  out  1  event available.
- EV_READY  in  1  consumer accepts the event.
- EV_DATA  out  IDX_BITS  SYNC_CODE or zero-extended pixel index.
- BUSY  out  1  state != IDLE.
- IMAGE_ENCODED  out  1  one-cycle pulse when the image is complete.
- EVENT_COUNT  out  $clog2(IMAGE_SIZE)+1  pixel events emitted for the current image; excludes sync events.

Behaviour:
- Clock and reset: single clock CLK; RST asynchronous, active-high.
- Reset values: state IDLE; EV_VALID 0; EV_DATA 0; BUSY 0; IMAGE_ENCODED 0; EVENT_COUNT 0; emitted mask all 0; intensity all-ones; group 0.
- States: IDLE, SYNC, SCAN, EMIT, DONE.
- Start:
  - IDLE & NEW_IMAGE: snapshot IMAGE and THRESHOLD; clear mask and EVENT_COUNT; intensity=max; group=0.
  - Next state SYNC if PRE_EVENTS>0, else SCAN.
  - Snapshot makes later IMAGE/THRESHOLD changes irrelevant. NEW_IMAGE outside IDLE is ignored.
- SYNC:
  - EV_VALID=1, EV_DATA=SYNC_CODE. EV_VALID rises the cycle after NEW_IMAGE.
  - Each EV_VALID&EV_READY counts one sync event. After PRE_EVENTS handshakes → SCAN.
- SCAN (one cycle per group of LANES pixels):
  - match[k] = (pix[group*LANES+k]==intensity) & ~mask[group*LANES+k].
  - Any match: take the lowest k; register EV_DATA=group*LANES+k; set its mask bit; EV_VALID=1; → EMIT. The group is not advanced, so remaining matches in it are re-evaluated.
  - No match, group not last: group+1.
  - No match, last group, intensity==THRESHOLD: → DONE.
  - No match, last group, otherwise: intensity-1, group=0.
- EMIT:
  - Hold EV_VALID and EV_DATA stable until EV_READY.
  - On handshake: EV_VALID=0; EVENT_COUNT+1. If the new count==IMAGE_SIZE → DONE (early exit, lower intensities not scanned); else → SCAN.
- DONE: IMAGE_ENCODED=1 for exactly one cycle; → IDLE.
- Throughput: at most one pixel event per 2 cycles. Worst-case scan cycles = 2^PIXEL_BITS*IMAGE_SIZE/LANES + 2*events.
- Threshold: pixels below THRESHOLD are never emitted. THRESHOLD=0 emits every pixel. THRESHOLD=max emits only max-valued pixels.
- EV_VALID may not drop without a handshake, except on ABORT or RST.
- ABORT:
  - In any non-IDLE state → IDLE next cycle. EV_VALID=0 that edge, even mid-handshake; no IMAGE_ENCODED.
  - EVENT_COUNT holds its value until the next start.
  - ABORT in IDLE has no effect.
- ABORT and EV_READY in the same cycle: ABORT wins. The event is considered not delivered and EVENT_COUNT does not increment.
- RST mid-operation: immediate return to reset values; the snapshot is discarded.

Test Plan:
- IMAGE_SIZE=8, LANES=4, PRE_EVENTS=2, image [3,7,7,0,5,7,1,2], THRESHOLD=0, EV_READY=1 → EV_DATA 0x0F,0x0F,1,2,5,4,0,7,6,3; then IMAGE_ENCODED pulse; EVENT_COUNT=8.
- Same image, THRESHOLD=3 → 0x0F,0x0F,1,2,5,4,0; then IMAGE_ENCODED; EVENT_COUNT=5; indices 3,6,7 absent.
- Same image, EV_READY low 5 cycles while event index 2 is presented → EV_VALID stays 1 and EV_DATA=2 stable; sequence unchanged; no duplicate or lost events.
- ABORT asserted while event index 5 is presented together with EV_READY=1 → IDLE next cycle; EV_VALID=0; no IMAGE_ENCODED; EVENT_COUNT=2. A following NEW_IMAGE restarts with both sync events.
- Default parameters, all pixels 255, EV_READY=1 → sync 0x1FF x2, then 0..255 in order; DONE directly after the 256th event, with no scan of intensity 254.
- NEW_IMAGE pulsed and IMAGE changed while BUSY → no restart; output matches the original snapshot.
